// File: rtl/valve_jk_driver.sv
// valve_jk_driver
//   Command-side controller for the JK flip-flop that holds the irrigation
//   valve state. An open request with a duration becomes a single-cycle J
//   pulse, the valve is verified open through Q_fb, the watering window is
//   timed, then a single-cycle K pulse closes the valve and the close is
//   verified. A failed verification parks the block in a sticky FAULT state
//   that keeps K asserted until Reset.
//
//   Optional build macro: TOGGLE_CMD_EN adds the Toggle input and the
//   TOGGLE / VERIFY_TOGGLE states (J = K = 1 for one cycle).
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   Start      in   open-and-water request (sampled in IDLE only)
//   Stop       in   abort watering, forces the close sequence
//   Duration   in   [DUR_W] watering length, captured with Start
//   Q_fb       in   q of the valve flip-flop (synchronous to Clk)
//   Toggle     in   (TOGGLE_CMD_EN only) request a J=K=1 toggle command
//   J, K       out  flip-flop drives, registered
//   Busy       out  high in every state except IDLE and FAULT
//   Done       out  one-cycle pulse after a verified close / toggle
//   Fault      out  sticky verification failure
//   Remaining  out  [DUR_W] watering cycles left
//   State      out  [4] debug view of the FSM state (IDLE = 0)
//
// Request semantics: Start, Stop and Toggle are level requests sampled on
// the rising edge of Clk. There is no acknowledge; a request is accepted
// exactly when the FSM leaves IDLE on that edge (visible as Busy/J/K one
// cycle later), otherwise it is dropped.

module valve_jk_driver #(
  parameter int DUR_W         = 8,
  parameter int VERIFY_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic [DUR_W-1:0] Duration,
  input  logic             Q_fb,
`ifdef TOGGLE_CMD_EN
  input  logic             Toggle,
`endif
  output logic             J,
  output logic             K,
  output logic             Busy,
  output logic             Done,
  output logic             Fault,
  output logic [DUR_W-1:0] Remaining,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_OPEN         = 4'd1,
    S_VERIFY_OPEN  = 4'd2,
    S_WATER        = 4'd3,
    S_CLOSE        = 4'd4,
    S_VERIFY_CLOSE = 4'd5,
`ifdef TOGGLE_CMD_EN
    S_TOGGLE        = 4'd7,
    S_VERIFY_TOGGLE = 4'd8,
`endif
    S_FAULT        = 4'd6
  } state_t;

  // Last value of the verify counter before a verification is declared
  // failed: the counter starts at 0 on entry, so VERIFY_CYCLES edges are
  // allowed in total.
  localparam logic [3:0] VC_LAST = 4'(VERIFY_CYCLES - 1);

  state_t           state_q, state_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
`ifdef TOGGLE_CMD_EN
  logic             tog_q, tog_d;
`endif

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
`ifdef TOGGLE_CMD_EN
      tog_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
`ifdef TOGGLE_CMD_EN
      tog_q   <= tog_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic (also the Remaining / verify counter / stop latch)
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = '0;      // verify counter restarts on every state change
    stop_d  = 1'b0;
`ifdef TOGGLE_CMD_EN
    tog_d   = tog_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Stop wins over Start; a zero duration is not a request.
        if (Start && !Stop && (Duration != '0)) begin
          state_d = S_OPEN;
          rem_d   = Duration;
        end
`ifdef TOGGLE_CMD_EN
        else if (Toggle && !Start && !Stop) begin
          state_d = S_TOGGLE;
          tog_d   = Q_fb;
        end
`endif
      end

      S_OPEN: begin
        // A Stop during the open pulse is remembered for the WATER entry.
        stop_d  = Stop;
        state_d = S_VERIFY_OPEN;
      end

      S_VERIFY_OPEN: begin
        stop_d = stop_q | Stop;
        if (Q_fb) begin
          // A pending stop makes the watering window zero cycles long.
          state_d = (stop_q || Stop) ? S_CLOSE : S_WATER;
        end else if (cnt_q == VC_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WATER: begin
        if (Stop) begin
          // Abort: Remaining keeps its current value until Done.
          state_d = S_CLOSE;
        end else begin
          if (rem_q != '0) rem_d = rem_q - DUR_W'(1);
          if (rem_q <= DUR_W'(1)) state_d = S_CLOSE;
        end
      end

      S_CLOSE: begin
        state_d = S_VERIFY_CLOSE;
      end

      S_VERIFY_CLOSE: begin
        if (!Q_fb) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else if (cnt_q == VC_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

`ifdef TOGGLE_CMD_EN
      S_TOGGLE: begin
        state_d = S_VERIFY_TOGGLE;
      end

      S_VERIFY_TOGGLE: begin
        if (Q_fb == !tog_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == VC_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: decoded from the next state so the registered outputs
  // line up with the state they belong to (J is high during OPEN).
  // ---------------------------------------------------------------------
  always_comb begin
    j_d     = 1'b0;
    k_d     = 1'b0;
    busy_d  = (state_d != S_IDLE) && (state_d != S_FAULT);
    done_d  = 1'b0;
    fault_d = (state_d == S_FAULT);

    case (state_d)
      S_OPEN:  j_d = 1'b1;
      S_CLOSE: k_d = 1'b1;
      S_FAULT: k_d = 1'b1;   // continuous force-close attempt
`ifdef TOGGLE_CMD_EN
      S_TOGGLE: begin
        j_d = 1'b1;
        k_d = 1'b1;
      end
`endif
      default: ;
    endcase

    if ((state_d == S_IDLE) && (state_q == S_VERIFY_CLOSE)) done_d = 1'b1;
`ifdef TOGGLE_CMD_EN
    if ((state_d == S_IDLE) && (state_q == S_VERIFY_TOGGLE)) done_d = 1'b1;
`endif
  end

  assign J         = j_q;
  assign K         = k_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Fault     = fault_q;
  assign Remaining = rem_q;
  assign State     = state_q;

endmodule
